// File: rtl/btn_conditioner.sv
`default_nettype none
// =============================================================================
// btn_conditioner : sync + debounce + press/auto-repeat latch for one button.
// Optional auto-repeat (DELAY/REPEAT FSM, ticks, mag) built with BTN_AUTOREPEAT_EN.
// Revision: 1.0
// =============================================================================
module btn_conditioner #(
  parameter int DEB_CNT  = 400000,
  parameter int HOLD_DLY = 16000000,
  parameter int REP_PER  = 2000000,
  parameter int MAG_STEP = 8,
  parameter int CNTW     = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  input  logic       mode,
  input  logic       clr,
  output logic       held,
  output logic       out,
  output logic       once,
  output logic [1:0] mag
);

  localparam logic [CNTW-1:0] DEB_LAST = CNTW'(DEB_CNT - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  logic            sync1;
  logic            sync2;
  logic            held_q;
  logic [CNTW-1:0] deb_cnt;
  logic            rise;
  logic            tick;

  assign rise = held & ~held_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      held    <= 1'b0;
      held_q  <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1  <= in;
      sync2  <= sync1;
      held_q <= held;
      // Any cycle agreeing with the accepted level restarts the stability count.
      if (sync2 != held) begin
        if (deb_cnt == DEB_LAST) begin
          held    <= sync2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + CNT_ONE;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      once <= 1'b0;
      out  <= 1'b0;
    end else begin
      if (rise)     once <= 1'b1;
      else if (clr) once <= 1'b0;

      // Level mode keeps a held button asserted across consumer acknowledges.
      if (!mode) begin
        if (held)     out <= 1'b1;
        else if (clr) out <= 1'b0;
      end else begin
        if (rise || tick) out <= 1'b1;
        else if (clr)     out <= 1'b0;
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD_DLY - 1);
  localparam logic [CNTW-1:0] REP_LAST  = CNTW'(REP_PER - 1);
  localparam int              RCW       = $clog2(MAG_STEP + 1);
  localparam logic [RCW-1:0]  MAG_LAST  = RCW'(MAG_STEP - 1);
  localparam logic [RCW-1:0]  RC_ONE    = RCW'(1);

  state_t          state;
  logic [CNTW-1:0] tmr;
  logic [RCW-1:0]  rep_cnt;
  logic [1:0]      mag_r;
  logic            fall;

  assign fall = ~held & held_q;
  // A release always wins over a tick falling due in the same cycle.
  assign tick = ~fall && (((state == DELAY)  && (tmr == HOLD_LAST)) ||
                          ((state == REPEAT) && (tmr == REP_LAST)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tmr     <= '0;
      rep_cnt <= '0;
      mag_r   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state <= DELAY;
            tmr   <= '0;
          end
        end
        DELAY: begin
          if (fall) begin
            state <= IDLE;
          end else if (tmr == HOLD_LAST) begin
            state <= REPEAT;
            tmr   <= '0;
          end else begin
            tmr <= tmr + CNT_ONE;
          end
        end
        REPEAT: begin
          if (fall)                 state <= IDLE;
          else if (tmr == REP_LAST) tmr   <= '0;
          else                      tmr   <= tmr + CNT_ONE;
        end
        default: state <= IDLE;
      endcase

      if (fall || state == IDLE) begin
        rep_cnt <= '0;
        mag_r   <= 2'd0;
      end else if (tick) begin
        if (rep_cnt == MAG_LAST) begin
          rep_cnt <= '0;
          if (mag_r != 2'd3) mag_r <= mag_r + 2'd1;
        end else begin
          rep_cnt <= rep_cnt + RC_ONE;
        end
      end
    end
  end

  assign mag = mag_r;
`else
  assign tick = 1'b0;
  assign mag  = 2'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// Scoreboard bench for btn_conditioner (DEB_CNT=4, HOLD_DLY=10, REP_PER=5, MAG_STEP=2).
// Expected {held,out,once,mag} snapshots are queued per cycle and checked on negedge.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in = 1'b0;
  logic       mode = 1'b1;
  logic       clr = 1'b0;
  logic       held;
  logic       out;
  logic       once;
  logic [1:0] mag;

  btn_conditioner #(
    .DEB_CNT (4),
    .HOLD_DLY(10),
    .REP_PER (5),
    .MAG_STEP(2),
    .CNTW    (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .mode(mode),
    .clr (clr),
    .held(held),
    .out (out),
    .once(once),
    .mag (mag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] v;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   base = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t e;
  logic [4:0] got;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation due at this cycle and compares it.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e      = q.pop_front();
      got    = {held, out, once, mag};
      checks = checks + 1;
      if (e.cyc != cyc || got !== e.v) begin
        errors = errors + 1;
        $display("FAIL %s @cyc %0d: got held/out/once/mag=%b expected %b (due cyc %0d)",
                 e.name, cyc, got, e.v, e.cyc);
      end
    end
  end

  task automatic start();
    base = cyc;
  endtask

  task automatic goto(input int t);
    while (cyc < base + t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input int t, input logic h, input logic o, input logic n,
                     input logic [1:0] m, input string nm);
    exp_t x;
    x.cyc  = base + t;
    x.v    = {h, o, n, m};
    x.name = nm;
    q.push_back(x);
  endtask

  task automatic settle();
    start();
    in  = 1'b0;
    clr = 1'b1;
    goto(1);
    clr = 1'b0;
    goto(14);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, queue=%0d", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    start();
    chk(0, 0, 0, 0, 2'd0, "reset");

    // Steady press: held after 2+DEB_CNT, then once/out; clr clears both.
    goto(1);
    start();
    rst  = 1'b0;
    mode = 1'b1;
    in   = 1'b1;
    chk(5, 0, 0, 0, 2'd0, "s1_before_held");
    chk(6, 1, 0, 0, 2'd0, "s1_held");
    chk(7, 1, 1, 1, 2'd0, "s1_once_out");
    chk(9, 1, 0, 0, 2'd0, "s1_clr");
    chk(15, 0, 0, 0, 2'd0, "s1_release");
    chk(20, 0, 0, 0, 2'd0, "s1_idle");
    goto(8);  clr = 1'b1;
    goto(9);  clr = 1'b0; in = 1'b0;
    goto(22);
    settle();

    // Bouncing input never stable for DEB_CNT cycles.
    start();
    chk(3, 0, 0, 0, 2'd0, "s2_bounce_a");
    chk(5, 0, 0, 0, 2'd0, "s2_bounce_b");
    chk(8, 0, 0, 0, 2'd0, "s2_bounce_c");
    chk(12, 0, 0, 0, 2'd0, "s2_bounce_d");
    chk(20, 0, 0, 0, 2'd0, "s2_bounce_e");
    in = 1'b1;
    goto(2); in = 1'b0;
    goto(4); in = 1'b1;
    goto(6); in = 1'b0;
    goto(22);
    settle();

    // Event mode, long hold, clr every cycle.
    start();
    in  = 1'b1;
    clr = 1'b1;
    chk(6, 1, 0, 0, 2'd0, "s3_held");
    chk(7, 1, 1, 1, 2'd0, "s3_rise");
    chk(8, 1, 0, 0, 2'd0, "s3_ack");
`ifdef BTN_AUTOREPEAT_EN
    chk(16, 1, 0, 0, 2'd0, "s3_pre_tick1");
    chk(17, 1, 1, 0, 2'd0, "s3_tick1");
    chk(18, 1, 0, 0, 2'd0, "s3_ack1");
    chk(22, 1, 1, 0, 2'd1, "s3_tick2_mag1");
    chk(23, 1, 0, 0, 2'd1, "s3_ack2");
    chk(27, 1, 1, 0, 2'd1, "s3_tick3");
    chk(32, 1, 1, 0, 2'd2, "s3_tick4_mag2");
    chk(42, 1, 1, 0, 2'd3, "s3_tick6_mag3");
    chk(52, 1, 1, 0, 2'd3, "s3_tick8_sat");
    chk(62, 1, 1, 0, 2'd3, "s3_tick10");
    chk(66, 0, 0, 0, 2'd3, "s3_fall");
    chk(67, 0, 0, 0, 2'd0, "s3_idle_no_tick");
`else
    chk(17, 1, 0, 0, 2'd0, "s3_no_tick1");
    chk(22, 1, 0, 0, 2'd0, "s3_no_tick2");
    chk(42, 1, 0, 0, 2'd0, "s3_no_tick6");
    chk(62, 1, 0, 0, 2'd0, "s3_no_tick10");
    chk(66, 0, 0, 0, 2'd0, "s3_fall");
    chk(67, 0, 0, 0, 2'd0, "s3_idle");
`endif
    chk(70, 0, 0, 0, 2'd0, "s3_quiet");
    goto(60); in = 1'b0;
    goto(71); clr = 1'b0;
    settle();

    // Level mode: short press held in out until the first clr after release.
    start();
    mode = 1'b0;
    in   = 1'b1;
    chk(6, 1, 0, 0, 2'd0, "s4_held");
    chk(7, 1, 1, 1, 2'd0, "s4_set");
    chk(8, 1, 1, 1, 2'd0, "s4_pre_clr");
    chk(9, 1, 1, 0, 2'd0, "s4_clr_while_held");
    chk(10, 0, 1, 0, 2'd0, "s4_released_kept");
    chk(14, 0, 1, 0, 2'd0, "s4_still_kept");
    chk(15, 0, 0, 0, 2'd0, "s4_cleared");
    chk(21, 0, 0, 0, 2'd0, "s4_stays_clear");
    goto(2);  clr = 1'b1;
    goto(3);  clr = 1'b0;
    goto(4);  in  = 1'b0;
    goto(8);  clr = 1'b1;
    goto(9);  clr = 1'b0;
    goto(14); clr = 1'b1;
    goto(15); clr = 1'b0;
    goto(20); clr = 1'b1;
    goto(21); clr = 1'b0;
    goto(23);
    settle();

    // Rise coincident with clr; release coincident with the due first tick.
    start();
    mode = 1'b1;
    in   = 1'b1;
    chk(6, 1, 0, 0, 2'd0, "s5_held");
    chk(7, 1, 1, 1, 2'd0, "s5_rise_beats_clr");
    chk(8, 1, 1, 1, 2'd0, "s5_latched");
    chk(10, 1, 0, 0, 2'd0, "s5_ack");
    chk(16, 0, 0, 0, 2'd0, "s5_fall");
    chk(17, 0, 0, 0, 2'd0, "s5_no_tick");
    chk(22, 0, 0, 0, 2'd0, "s5_idle");
    goto(6);  clr = 1'b1;
    goto(7);  clr = 1'b0;
    goto(9);  clr = 1'b1;
    goto(10); clr = 1'b0; in = 1'b0;
    goto(25);
    settle();

    // Reset mid-press: re-debounce and a fresh rise/once.
    start();
    in = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
    chk(27, 1, 1, 1, 2'd1, "s6_repeating");
`else
    chk(27, 1, 1, 1, 2'd0, "s6_pressed");
`endif
    chk(29, 0, 0, 0, 2'd0, "s6_reset");
    chk(34, 0, 0, 0, 2'd0, "s6_redebounce");
    chk(35, 1, 0, 0, 2'd0, "s6_held_again");
    chk(36, 1, 1, 1, 2'd0, "s6_once_again");
    chk(38, 1, 0, 0, 2'd0, "s6_ack");
    chk(50, 0, 0, 0, 2'd0, "s6_final");
    goto(28); rst = 1'b1;
    goto(29); rst = 1'b0;
    goto(37); clr = 1'b1; in = 1'b0;
    goto(38); clr = 1'b0;
    goto(52);

    for (int i = 0; i < 100 && q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expectations never checked, required 0", q.size());
      errors = errors + q.size();
      checks = checks + q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
